// File: rtl/gamepad_reader.sv
// NES/SNES serial controller reader: latches the pad, shifts BUTTONS bits out with
// a slow pad_clk, and publishes the result with valid/changed pulses and a sticky OR.
module gamepad_reader #(
  parameter int BUTTONS     = 8,
  parameter int HALF_PERIOD = 162,
  parameter int POLL_CYCLES = 450000
) (
  input  logic               raw_clk,
  input  logic               reset,
  input  logic               start,
  input  logic               auto_poll,
  input  logic               sticky_clear,
  output logic               pad_latch,
  output logic               pad_clk,
  input  logic               pad_data,
  output logic [BUTTONS-1:0] buttons,
  output logic [BUTTONS-1:0] sticky,
  output logic               valid,
  output logic               changed,
  output logic               busy
);

  localparam int PW = $clog2(2*HALF_PERIOD);
  localparam int IW = (BUTTONS > 1) ? $clog2(BUTTONS) : 1;
  localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  localparam logic [PW-1:0] PH_H_LAST  = PW'(HALF_PERIOD-1);
  localparam logic [PW-1:0] PH_2H_LAST = PW'(2*HALF_PERIOD-1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(BUTTONS-1);
  localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_CYCLES-1);

  typedef enum logic [2:0] {IDLE, LATCH, READ, LOW, DONE} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ph_q, ph_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [BUTTONS-1:0] shift_q, shift_d;
  logic [BUTTONS-1:0] buttons_q, sticky_q;
  logic               latch_q, clk_q, valid_q, changed_q;
  logic               sync1_q, sync2_q;
  logic [TW-1:0]      poll_q;
  logic               tick;

  assign tick = auto_poll && (poll_q == POLL_LAST);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q + PW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        ph_d = '0;
        if (start || tick) begin
          idx_d   = '0;
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (ph_q == PH_2H_LAST) begin
          ph_d    = '0;
          state_d = READ;
        end
      end
      READ: begin
        // Sample at the end of the high half so the synchronised bit has settled.
        if (ph_q == PH_H_LAST) begin
          ph_d           = '0;
          shift_d[idx_q] = ~sync2_q;
          state_d        = (idx_q == IDX_LAST) ? DONE : LOW;
        end
      end
      LOW: begin
        if (ph_q == PH_H_LAST) begin
          ph_d    = '0;
          idx_d   = idx_q + IW'(1);
          state_d = READ;
        end
      end
      DONE: begin
        ph_d    = '0;
        state_d = IDLE;
      end
      default: begin
        ph_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      sticky_q  <= '0;
      latch_q   <= 1'b0;
      clk_q     <= 1'b1;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      poll_q    <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      sync1_q   <= pad_data;
      sync2_q   <= sync1_q;
      poll_q    <= (poll_q == POLL_LAST) ? '0 : poll_q + TW'(1);
      latch_q   <= (state_d == LATCH);
      clk_q     <= (state_d != LOW);
      // buttons/valid/changed land together so the DONE cycle shows a coherent result.
      valid_q   <= (state_d == DONE);
      changed_q <= (state_d == DONE) && (shift_d != buttons_q);
      if (state_d == DONE)
        buttons_q <= shift_d;
      // A clear coinciding with DONE wipes old history but keeps this read.
      if (state_q == DONE)
        sticky_q <= (sticky_clear ? '0 : sticky_q) | shift_q;
      else if (sticky_clear)
        sticky_q <= '0;
    end
  end

  assign pad_latch = latch_q;
  assign pad_clk   = clk_q;
  assign buttons   = buttons_q;
  assign sticky    = sticky_q;
  assign valid     = valid_q;
  assign changed   = changed_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gamepad_reader.sv
// Directed bench for gamepad_reader with a 74HC4021-style pad model.
module tb_gamepad_reader;

  logic       raw_clk = 1'b0;
  logic       reset, start, auto_poll, sticky_clear;
  logic       pad_latch, pad_clk, pad_data;
  logic [7:0] buttons, sticky;
  logic       valid, changed, busy;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;

  logic [7:0] pad_bits = 8'h00;
  logic [7:0] sr       = 8'hFF;
  logic       ovr_en   = 1'b0;
  logic       ovr_val  = 1'b1;

  gamepad_reader #(.BUTTONS(8), .HALF_PERIOD(4), .POLL_CYCLES(200)) dut (
    .raw_clk(raw_clk), .reset(reset), .start(start), .auto_poll(auto_poll),
    .sticky_clear(sticky_clear), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .pad_data(pad_data), .buttons(buttons), .sticky(sticky), .valid(valid),
    .changed(changed), .busy(busy)
  );

  always #5 raw_clk = ~raw_clk;

  // Parallel load while latched, shift toward Q8 on each rising pad_clk.
  always @(posedge pad_clk or posedge pad_latch)
    if (pad_latch) sr <= ~pad_bits;
    else           sr <= {1'b1, sr[7:1]};

  assign pad_data = ovr_en ? ovr_val : sr[0];

  always @(negedge raw_clk)
    if (valid === 1'b1) vcnt <= vcnt + 1;

  task automatic step();
    @(posedge raw_clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Start at edge T, then observe cycles T+1..T+ncyc; masks drive start/pad_data per cycle.
  task automatic run_cycles(input int ncyc, input logic [255:0] smask,
                            input logic [255:0] omask, input logic [255:0] ovals,
                            output int lat, output int nval,
                            output logic [7:0] b, output logic ch);
    lat  = -1;
    nval = 0;
    b    = 8'h00;
    ch   = 1'b0;
    start = 1'b1;
    step();
    for (int k = 1; k <= ncyc; k++) begin
      if (valid === 1'b1) begin
        nval++;
        if (lat < 0) begin
          lat = k;
          b   = buttons;
          ch  = changed;
        end
      end
      start   = smask[k];
      ovr_en  = omask[k];
      ovr_val = ovals[k];
      step();
    end
    start  = 1'b0;
    ovr_en = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = -1;
    for (int k = 0; k <= maxc; k++) begin
      if (valid === 1'b1) begin
        n = k;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks += 7;
    if (pad_latch !== 1'b0) begin errors++; $display("FAIL rst_latch got %b want 0", pad_latch); end
    if (pad_clk !== 1'b1)   begin errors++; $display("FAIL rst_clk got %b want 1", pad_clk); end
    if (buttons !== 8'h00)  begin errors++; $display("FAIL rst_buttons got %h want 00", buttons); end
    if (sticky !== 8'h00)   begin errors++; $display("FAIL rst_sticky got %h want 00", sticky); end
    if (valid !== 1'b0)     begin errors++; $display("FAIL rst_valid got %b want 0", valid); end
    if (changed !== 1'b0)   begin errors++; $display("FAIL rst_changed got %b want 0", changed); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_read();
    int lat_first = -1, lat_last = -1, nlatch = 0, nlow = 0, nfall = 0, vk = -1, nv = 0;
    logic prev_clk = 1'b1;
    logic busy1 = 1'b0, busy69 = 1'b0, busy70 = 1'b1, ch = 1'b0;
    logic [7:0] b = 8'h00;
    pad_bits = 8'hA5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      if (pad_latch === 1'b1) begin
        nlatch++;
        if (lat_first < 0) lat_first = k;
        lat_last = k;
      end
      if (pad_clk === 1'b0) nlow++;
      if (prev_clk === 1'b1 && pad_clk === 1'b0) nfall++;
      prev_clk = pad_clk;
      if (valid === 1'b1) begin
        nv++;
        vk = k;
        b  = buttons;
        ch = changed;
      end
      if (k == 1)  busy1  = busy;
      if (k == 69) busy69 = busy;
      if (k == 70) busy70 = busy;
      step();
    end
    checks += 11;
    if (lat_first !== 1) begin errors++; $display("FAIL latch_first got %0d want 1", lat_first); end
    if (lat_last !== 8)  begin errors++; $display("FAIL latch_last got %0d want 8", lat_last); end
    if (nlatch !== 8)    begin errors++; $display("FAIL latch_len got %0d want 8", nlatch); end
    if (nfall !== 7)     begin errors++; $display("FAIL clk_pulses got %0d want 7", nfall); end
    if (nlow !== 28)     begin errors++; $display("FAIL clk_low_cycles got %0d want 28", nlow); end
    if (vk !== 69 || nv !== 1) begin errors++; $display("FAIL valid_at got %0d (n=%0d) want 69 (n=1)", vk, nv); end
    if (b !== 8'hA5)     begin errors++; $display("FAIL buttons1 got %h want a5", b); end
    if (ch !== 1'b1)     begin errors++; $display("FAIL changed1 got %b want 1", ch); end
    if (busy1 !== 1'b1)  begin errors++; $display("FAIL busy_start got %b want 1", busy1); end
    if (busy69 !== 1'b1) begin errors++; $display("FAIL busy_done got %b want 1", busy69); end
    if (busy70 !== 1'b0) begin errors++; $display("FAIL busy_after got %b want 0", busy70); end
  endtask

  task automatic test_repeat();
    int lat, nv;
    logic [7:0] b;
    logic ch;
    run_cycles(72, '0, '0, '0, lat, nv, b, ch);
    checks += 3;
    if (lat !== 69)  begin errors++; $display("FAIL rep_latency got %0d want 69", lat); end
    if (b !== 8'hA5) begin errors++; $display("FAIL rep_buttons got %h want a5", b); end
    if (ch !== 1'b0) begin errors++; $display("FAIL rep_changed got %b want 0", ch); end
  endtask

  task automatic test_back_to_back();
    int lat, nv;
    logic [7:0] b;
    logic ch;
    logic [255:0] sm;
    sm = '0;
    sm[10] = 1'b1;
    sm[40] = 1'b1;
    pad_bits = 8'h3C;
    run_cycles(150, sm, '0, '0, lat, nv, b, ch);
    checks += 3;
    if (nv !== 1)    begin errors++; $display("FAIL drop_nvalid got %0d want 1", nv); end
    if (lat !== 69)  begin errors++; $display("FAIL drop_latency got %0d want 69", lat); end
    if (b !== 8'h3C) begin errors++; $display("FAIL drop_buttons got %h want 3c", b); end
    pad_bits = 8'hA5;
    run_cycles(72, '0, '0, '0, lat, nv, b, ch);
    checks += 3;
    if (lat !== 69)  begin errors++; $display("FAIL drop_next_lat got %0d want 69", lat); end
    if (b !== 8'hA5) begin errors++; $display("FAIL drop_next_btn got %h want a5", b); end
    if (ch !== 1'b1) begin errors++; $display("FAIL drop_next_chg got %b want 1", ch); end
  endtask

  task automatic test_auto_poll();
    int n1, n2, n3;
    apply_reset();
    pad_bits  = 8'h01;
    auto_poll = 1'b1;
    wait_valid(400, n1);
    checks += 2;
    if (n1 < 0)           begin errors++; $display("FAIL poll1_timeout got %0d want >=0", n1); end
    if (buttons !== 8'h01) begin errors++; $display("FAIL poll1_buttons got %h want 01", buttons); end
    step();
    pad_bits = 8'h80;
    checks++;
    if (sticky !== 8'h01) begin errors++; $display("FAIL poll1_sticky got %h want 01", sticky); end
    wait_valid(400, n2);
    checks += 2;
    if (n2 !== 199)        begin errors++; $display("FAIL poll2_period got %0d want 199", n2); end
    if (buttons !== 8'h80) begin errors++; $display("FAIL poll2_buttons got %h want 80", buttons); end
    step();
    checks++;
    if (sticky !== 8'h81) begin errors++; $display("FAIL poll2_sticky got %h want 81", sticky); end
    wait_valid(400, n3);
    sticky_clear = 1'b1;
    step();
    sticky_clear = 1'b0;
    checks += 2;
    if (n3 !== 199)       begin errors++; $display("FAIL poll3_period got %0d want 199", n3); end
    if (sticky !== 8'h80) begin errors++; $display("FAIL clr_at_done got %h want 80", sticky); end
    auto_poll    = 1'b0;
    sticky_clear = 1'b1;
    step();
    sticky_clear = 1'b0;
    checks++;
    if (sticky !== 8'h00) begin errors++; $display("FAIL clr_idle got %h want 00", sticky); end
  endtask

  task automatic test_reset_mid_read();
    int v0, lat, nv;
    logic [7:0] b;
    logic ch;
    pad_bits = 8'hA5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 46; k++) step();
    checks++;
    if (pad_clk !== 1'b0) begin errors++; $display("FAIL abort_in_low got %b want 0", pad_clk); end
    reset = 1'b1;
    step();
    checks += 5;
    if (pad_latch !== 1'b0) begin errors++; $display("FAIL abort_latch got %b want 0", pad_latch); end
    if (pad_clk !== 1'b1)   begin errors++; $display("FAIL abort_clk got %b want 1", pad_clk); end
    if (buttons !== 8'h00)  begin errors++; $display("FAIL abort_buttons got %h want 00", buttons); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    if (valid !== 1'b0)     begin errors++; $display("FAIL abort_valid got %b want 0", valid); end
    reset = 1'b0;
    v0 = vcnt;
    for (int k = 0; k < 80; k++) step();
    checks++;
    if (vcnt !== v0) begin errors++; $display("FAIL abort_no_valid got %0d want %0d", vcnt, v0); end
    run_cycles(72, '0, '0, '0, lat, nv, b, ch);
    checks += 2;
    if (lat !== 69)  begin errors++; $display("FAIL abort_next_lat got %0d want 69", lat); end
    if (b !== 8'hA5) begin errors++; $display("FAIL abort_next_btn got %h want a5", b); end
  endtask

  task automatic test_sync_glitch();
    int lat, nv;
    logic [7:0] b;
    logic ch;
    logic [255:0] om, ov;
    // Glitches in LATCH, LOW_2 and non-sampled READ_3 cycles.
    om = '0;
    ov = '0;
    for (int k = 3; k <= 5; k++)   begin om[k] = 1'b1; ov[k] = k[0]; end
    for (int k = 29; k <= 33; k++) begin om[k] = 1'b1; ov[k] = k[0]; end
    om[35] = 1'b1; ov[35] = 1'b0;
    om[36] = 1'b1; ov[36] = 1'b1;
    pad_bits = 8'hA5;
    run_cycles(72, '0, om, ov, lat, nv, b, ch);
    checks++;
    if (b !== 8'hA5) begin errors++; $display("FAIL glitch_buttons got %h want a5", b); end
    // Bit 0 reflects pad_data from cycle T+10 only (sampled at T+12 through two flops).
    om = '1;
    ov = '1;
    ov[10] = 1'b0;
    ovr_en = 1'b1; ovr_val = 1'b1;
    run_cycles(72, '0, om, ov, lat, nv, b, ch);
    checks++;
    if (b !== 8'h01) begin errors++; $display("FAIL lag_hit got %h want 01", b); end
    ov = '1;
    ov[9]  = 1'b0;
    ov[11] = 1'b0;
    ovr_en = 1'b1; ovr_val = 1'b1;
    run_cycles(72, '0, om, ov, lat, nv, b, ch);
    checks++;
    if (b !== 8'h00) begin errors++; $display("FAIL lag_miss got %h want 00", b); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; auto_poll = 1'b0; sticky_clear = 1'b0;
    test_reset();
    test_basic_read();
    test_repeat();
    test_back_to_back();
    test_auto_poll();
    test_reset_mid_read();
    test_sync_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
